bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Port clk  input  1  system clock; all state updates on rising edge.
REQ-002 Port reset  input  1  asynchronous, active-high reset.
REQ-003 Port m0_req_n  input  1  bus request from master 0, active-low; fed by a CPU bus_if bus_req_n.
REQ-004 Port m1_req_n  input  1  bus request from master 1, active-low.
REQ-005 Port m2_req_n  input  1  bus request from master 2, active-low.
REQ-006 Port m3_req_n  input  1  bus request from master 3, active-low.
REQ-007 Port m0_grnt_n  output  1  grant to master 0, active-low; drives that bus_if's bus_grnt_n.
REQ-008 Port m1_grnt_n  output  1  grant to master 1, active-low.
REQ-009 Port m2_grnt_n  output  1  grant to master 2, active-low.
REQ-010 Port m3_grnt_n  output  1  grant to master 3, active-low.
REQ-011 Port owner  output  2  index of current bus owner; select input for the downstream master multiplexer.

Function
REQ-012 The arbiter SHALL hold a 2-bit owner register; owner output SHALL equal it directly.
REQ-013 Grant outputs SHALL be a combinational one-hot-low decode of owner: exactly one mN_grnt_n low at all times, including with no requests pending.
REQ-014 While the current owner's req_n is low, owner SHALL NOT change (no preemption, no hold limit).
REQ-015 When the current owner's req_n is high at a rising edge, the next owner SHALL be the first master with req_n low, searched in order owner+1, owner+2, owner+3 (mod 4).
REQ-016 If no master requests, owner SHALL remain unchanged (parked grant).
REQ-017 Search index arithmetic SHALL wrap modulo 4 (3+1 -> 0).
REQ-018 A master that requests while already parked-owner SHALL see its grant in the same cycle (zero-cycle grant latency).
REQ-019 A master that requests while another master owns the bus SHALL be granted on the rising edge after the owner deasserts req_n, provided no master earlier in round-robin order also requests.
REQ-020 Worst-case wait from request to grant SHALL be bounded by three other masters' tenures plus three cycles.
REQ-021 Simultaneous owner release and multiple new requests SHALL resolve strictly by round-robin order from the releasing owner; the releasing owner SHALL rank lowest.
REQ-022 Glitches on req_n of non-owners between edges SHALL have no effect; only values sampled at the rising edge matter.

Reset
REQ-023 Assertion of reset SHALL immediately, asynchronously set owner to 0: m0_grnt_n low, m1/m2/m3_grnt_n high.
REQ-024 Reset asserted mid-tenure SHALL abandon the tenure with no pending-state retention; after deassertion arbitration resumes per REQ-014 to REQ-016 from owner 0.

Structure
REQ-025 Owner encodings (2'h0 to 2'h3), owner width and master count SHALL be defined in the shared bus definition header beside the existing bus slave index constants.
REQ-026 ENABLE_/DISABLE_ and RESET_EDGE/RESET_ENABLE levels SHALL come from the shared global standard definition header.
REQ-027 The block SHALL be a single module with no sub-modules; the next-owner search SHALL be a combinational block feeding the owner register.

Verification
REQ-028 Reset pulse, no requests -> owner=0, grant pattern m0..m3 = 0,1,1,1; stays so for 10 cycles.
REQ-029 Owner 0, m2_req_n low only -> on cycle 0 still owner 0; after m0 idle edge, owner=2, m2_grnt_n low next cycle.
REQ-030 Owner 1 holding req low for 20 cycles, m0/m2/m3 requesting -> owner stays 1 for all 20; on release, owner=2.
REQ-031 Owner 3 releases with m0 and m1 requesting -> owner=0 (wrap); then m0 releases -> owner=1.
REQ-032 Owner 2, m2 requests again immediately after release while m3 requests -> owner=3, m2 waits for its next turn.
REQ-033 Reset asserted while owner=3 and m3_req_n low -> owner=0 asynchronously, before the next clock edge; after release with m3 still requesting and m0 idle, owner=3 one edge later.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions for the master arbiter: owner encodings, widths and
// the enable/reset levels used by the bus blocks.
package bus_arbiter_pkg;

    localparam int NUM_MASTERS = 4;
    localparam int OWNER_W     = 2;

    typedef logic [OWNER_W-1:0] owner_t;

    localparam owner_t OWNER_M0 = 2'h0;
    localparam owner_t OWNER_M1 = 2'h1;
    localparam owner_t OWNER_M2 = 2'h2;
    localparam owner_t OWNER_M3 = 2'h3;

    localparam logic ENABLE_      = 1'b1;
    localparam logic DISABLE_     = 1'b0;
    localparam logic RESET_ENABLE = 1'b1;

endpackage

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with parked grant and no preemption.
// Grants are an active-low one-hot decode of the owner register.
module bus_arbiter
    import bus_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               m0_req_n,
    input  logic               m1_req_n,
    input  logic               m2_req_n,
    input  logic               m3_req_n,
    output logic               m0_grnt_n,
    output logic               m1_grnt_n,
    output logic               m2_grnt_n,
    output logic               m3_grnt_n,
    output logic [OWNER_W-1:0] owner
);

    owner_t                 owner_q;
    owner_t                 owner_d;
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] grnt_n;

    assign req = ~{m3_req_n, m2_req_n, m1_req_n, m0_req_n};

    // The owner keeps the bus while requesting; otherwise search owner+1..owner+3
    // so the releasing master always ranks last. No requester leaves the grant parked.
    always_comb begin
        owner_t cand;
        logic   found;
        owner_d = owner_q;
        found   = DISABLE_;
        cand    = owner_q;
        if (req[owner_q] == DISABLE_) begin
            for (int k = 1; k < NUM_MASTERS; k++) begin
                cand = owner_q + owner_t'(k);
                if (found == DISABLE_ && req[cand] == ENABLE_) begin
                    owner_d = cand;
                    found   = ENABLE_;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset == RESET_ENABLE) begin
            owner_q <= OWNER_M0;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        grnt_n = '1;
        case (owner_q)
            OWNER_M0: grnt_n = 4'b1110;
            OWNER_M1: grnt_n = 4'b1101;
            OWNER_M2: grnt_n = 4'b1011;
            OWNER_M3: grnt_n = 4'b0111;
            default:  grnt_n = 4'b1110;
        endcase
    end

    assign owner     = owner_q;
    assign m0_grnt_n = grnt_n[0];
    assign m1_grnt_n = grnt_n[1];
    assign m2_grnt_n = grnt_n[2];
    assign m3_grnt_n = grnt_n[3];

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random requests
// compared against a round-robin reference model of owner and grants.
module tb_bus_arbiter;

    logic       clk;
    logic       reset;
    logic       m0_req_n, m1_req_n, m2_req_n, m3_req_n;
    logic       m0_grnt_n, m1_grnt_n, m2_grnt_n, m3_grnt_n;
    logic [1:0] owner;

    int errors = 0;
    int checks = 0;
    int model_owner = 0;

    bus_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req_n  (m0_req_n),
        .m1_req_n  (m1_req_n),
        .m2_req_n  (m2_req_n),
        .m3_req_n  (m3_req_n),
        .m0_grnt_n (m0_grnt_n),
        .m1_grnt_n (m1_grnt_n),
        .m2_grnt_n (m2_grnt_n),
        .m3_grnt_n (m3_grnt_n),
        .owner     (owner)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Expected grant vector {m3..m0}: only the owner's line is low.
    function automatic logic [3:0] exp_grants(input int own);
        logic [3:0] g;
        g = 4'b1111;
        g[own] = 1'b0;
        return g;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_owner"}, {6'd0, owner}, 8'(model_owner));
        check({tag, "_grnt"}, {4'd0, m3_grnt_n, m2_grnt_n, m1_grnt_n, m0_grnt_n},
              {4'd0, exp_grants(model_owner)});
    endtask

    // Round-robin reference: owner keeps the bus while requesting, otherwise the
    // first requester at distance 1..3 wins; nobody requesting parks the grant.
    function automatic int model_next(input int own, input logic [3:0] req);
        if (req[own]) return own;
        for (int d = 1; d < 4; d++) begin
            if (req[(own + d) % 4]) return (own + d) % 4;
        end
        return own;
    endfunction

    task automatic drive_req(input logic [3:0] req);
        {m3_req_n, m2_req_n, m1_req_n, m0_req_n} = ~req;
    endtask

    // Drive requests (active-high view) at negedge, clock once, check at next negedge.
    task automatic step(input logic [3:0] req, input string tag);
        drive_req(req);
        @(posedge clk);
        model_owner = model_next(model_owner, req);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive_req(4'b0000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_owner = 0;
    endtask

    initial begin
        reset = 1'b0;
        drive_req(4'b0000);
        @(negedge clk);
        apply_reset();
        check_outputs("reset");

        // idle parking for 10 cycles
        for (int i = 0; i < 10; i++) step(4'b0000, "park0");

        // owner 0 requesting, m2 requests: no change, then m0 idles -> m2
        step(4'b0101, "hold0");
        step(4'b0100, "to2");
        check("to2_exact", {6'd0, owner}, 8'd2);

        // glitch on a non-owner between edges has no effect
        drive_req(4'b0100);
        #2 drive_req(4'b0101);
        #1 drive_req(4'b0100);
        step(4'b0100, "glitch");

        // reach owner 1, hold 20 cycles with everyone else requesting
        step(4'b0010, "to1");
        for (int i = 0; i < 20; i++) step(4'b1111, "hold1");
        check("hold1_exact", {6'd0, owner}, 8'd1);
        step(4'b1101, "rel1");
        check("rel1_exact", {6'd0, owner}, 8'd2);

        // owner 2 releases, m2 re-requests with m3 requesting -> m3 first
        step(4'b1000, "to3");
        step(4'b1100, "m2wait");
        check("m2wait_exact", {6'd0, owner}, 8'd3);

        // owner 3 releases with m0,m1 requesting -> wrap to 0, then 1
        step(4'b0011, "wrap0");
        check("wrap0_exact", {6'd0, owner}, 8'd0);
        step(4'b0010, "then1");
        check("then1_exact", {6'd0, owner}, 8'd1);

        // reset mid-tenure while owner 3 requests
        step(4'b1000, "pre_rst3");
        check("pre_rst3_exact", {6'd0, owner}, 8'd3);
        #2 reset = 1'b1;
        #1 model_owner = 0;
        check_outputs("async_rst");
        @(negedge clk);
        reset = 1'b0;
        step(4'b1000, "post_rst");
        check("post_rst_exact", {6'd0, owner}, 8'd3);

        // randomized stimulus; keep the owner's request asserted some of the time
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) r[model_owner] = 1'b1;
            if ($urandom_range(0, 5) == 0) r[model_owner] = 1'b0;
            step(r, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
